// File: rtl/video_timing_pkg.sv
// Shared axis-timing types and helpers for the configurable video sync generator.
// Fields are FIELD_W wide so one struct serves any counter width up to that size.
package video_timing_pkg;

    localparam int unsigned FIELD_W  = 16;
    localparam int unsigned SUM_W    = FIELD_W + 3;
    localparam int unsigned N_FIELDS = 6;

    // Slot of each field inside a 6-field config word; F_VIS sits in the MSBs.
    localparam int unsigned F_BORDER2 = 0;
    localparam int unsigned F_BPORCH  = 1;
    localparam int unsigned F_SYNC    = 2;
    localparam int unsigned F_FPORCH  = 3;
    localparam int unsigned F_BORDER1 = 4;
    localparam int unsigned F_VIS     = 5;

    typedef struct packed {
        logic [FIELD_W-1:0] vis;
        logic [FIELD_W-1:0] border1;
        logic [FIELD_W-1:0] fporch;
        logic [FIELD_W-1:0] sync;
        logic [FIELD_W-1:0] bporch;
        logic [FIELD_W-1:0] border2;
    } axis_timing_t;

    function automatic logic [SUM_W-1:0] total(input axis_timing_t t);
        return SUM_W'(t.vis) + SUM_W'(t.border1) + SUM_W'(t.fporch) +
               SUM_W'(t.sync) + SUM_W'(t.bporch) + SUM_W'(t.border2);
    endfunction

    function automatic logic [SUM_W-1:0] sync_start(input axis_timing_t t);
        return SUM_W'(t.vis) + SUM_W'(t.border1) + SUM_W'(t.fporch);
    endfunction

    // Usable only with a visible and a sync region and a total the counter can hold.
    function automatic logic valid_cfg(input axis_timing_t t, input int unsigned cnt_w);
        logic [SUM_W:0] limit;
        limit = (SUM_W+1)'(1) << cnt_w;
        return (t.vis != '0) && (t.sync != '0) && ({1'b0, total(t)} < limit);
    endfunction

endpackage

// File: rtl/video_axis_counter.sv
// One timing axis: position counter with wrap, plus registered sync and blank decode.
// blank_nxt exposes the value blank will take after this cycle for aligned combining.
module video_axis_counter
    import video_timing_pkg::*;
#(
    parameter int unsigned CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  axis_timing_t     timing,
    output logic [CNT_W-1:0] pos,
    output logic             last,
    output logic             sync_act,
    output logic             blank,
    output logic             blank_nxt
);

    logic [SUM_W-1:0] tot;
    logic [SUM_W-1:0] s_lo;
    logic [SUM_W-1:0] s_hi;
    logic [SUM_W-1:0] p_nxt;
    logic [CNT_W-1:0] pos_nxt;
    logic             sync_nxt;

    always_comb begin
        tot      = total(timing);
        s_lo     = sync_start(timing);
        s_hi     = s_lo + SUM_W'(timing.sync);
        last     = (SUM_W'(pos) == tot - SUM_W'(1));
        pos_nxt  = pos;
        if (step) begin
            pos_nxt = last ? '0 : pos + 1'b1;
        end
        // Position 0 decodes identically under any valid timing, so a timing swap at wrap is safe.
        p_nxt     = SUM_W'(pos_nxt);
        blank_nxt = (p_nxt >= SUM_W'(timing.vis));
        sync_nxt  = (p_nxt >= s_lo) && (p_nxt < s_hi);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos      <= '0;
            sync_act <= 1'b0;
            blank    <= 1'b0;
        end else if (step) begin
            pos      <= pos_nxt;
            sync_act <= sync_nxt;
            blank    <= blank_nxt;
        end
    end

endmodule

// File: rtl/video_timing_gen_cfg.sv
// Runtime-reconfigurable video sync generator: H/V axis counters, shadowed timing
// config via valid/ready, applied only at the frame wrap.
module video_timing_gen_cfg
    import video_timing_pkg::*;
#(
    parameter int unsigned CNT_W           = 10,
    parameter int unsigned FRAME_CNT_W     = 8,
    parameter int unsigned H_VISIBLE       = 640,
    parameter int unsigned H_RIGHT_BORDER  = 8,
    parameter int unsigned H_FRONT_PORCH   = 8,
    parameter int unsigned H_SYNC_TIME     = 96,
    parameter int unsigned H_BACK_PORCH    = 40,
    parameter int unsigned H_LEFT_BORDER   = 8,
    parameter int unsigned V_VISIBLE       = 480,
    parameter int unsigned V_BOTTOM_BORDER = 8,
    parameter int unsigned V_FRONT_PORCH   = 2,
    parameter int unsigned V_SYNC_TIME     = 2,
    parameter int unsigned V_BACK_PORCH    = 25,
    parameter int unsigned V_TOP_BORDER    = 8,
    parameter int unsigned HSYNC_POL       = 0,
    parameter int unsigned VSYNC_POL       = 0
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_ce,
    input  logic                      i_cfg_valid,
    output logic                      o_cfg_ready,
    input  logic [N_FIELDS*CNT_W-1:0] i_cfg_h,
    input  logic [N_FIELDS*CNT_W-1:0] i_cfg_v,
    output logic                      o_cfg_err,
    output logic                      o_hsync,
    output logic                      o_vsync,
    output logic                      o_hblank,
    output logic                      o_vblank,
    output logic                      o_visible,
    output logic [CNT_W-1:0]          o_hpos,
    output logic [CNT_W-1:0]          o_vpos,
    output logic                      o_line_start,
    output logic                      o_frame_start,
    output logic [FRAME_CNT_W-1:0]    o_frame_cnt
);

    localparam axis_timing_t H_RST = '{
        vis:     FIELD_W'(H_VISIBLE),
        border1: FIELD_W'(H_RIGHT_BORDER),
        fporch:  FIELD_W'(H_FRONT_PORCH),
        sync:    FIELD_W'(H_SYNC_TIME),
        bporch:  FIELD_W'(H_BACK_PORCH),
        border2: FIELD_W'(H_LEFT_BORDER)
    };

    localparam axis_timing_t V_RST = '{
        vis:     FIELD_W'(V_VISIBLE),
        border1: FIELD_W'(V_BOTTOM_BORDER),
        fporch:  FIELD_W'(V_FRONT_PORCH),
        sync:    FIELD_W'(V_SYNC_TIME),
        bporch:  FIELD_W'(V_BACK_PORCH),
        border2: FIELD_W'(V_TOP_BORDER)
    };

    function automatic axis_timing_t to_timing(input logic [N_FIELDS*CNT_W-1:0] bus);
        axis_timing_t t;
        t.vis     = FIELD_W'(bus[F_VIS*CNT_W     +: CNT_W]);
        t.border1 = FIELD_W'(bus[F_BORDER1*CNT_W +: CNT_W]);
        t.fporch  = FIELD_W'(bus[F_FPORCH*CNT_W  +: CNT_W]);
        t.sync    = FIELD_W'(bus[F_SYNC*CNT_W    +: CNT_W]);
        t.bporch  = FIELD_W'(bus[F_BPORCH*CNT_W  +: CNT_W]);
        t.border2 = FIELD_W'(bus[F_BORDER2*CNT_W +: CNT_W]);
        return t;
    endfunction

    axis_timing_t h_act;
    axis_timing_t v_act;
    axis_timing_t h_shadow;
    axis_timing_t v_shadow;
    axis_timing_t h_new;
    axis_timing_t v_new;

    logic cfg_ok;
    logic offer;
    logic h_last;
    logic v_last;
    logic v_step;
    logic frame_wrap;
    logic h_sync_act;
    logic v_sync_act;
    logic h_blank_nxt;
    logic v_blank_nxt;

    always_comb begin
        h_new      = to_timing(i_cfg_h);
        v_new      = to_timing(i_cfg_v);
        cfg_ok     = valid_cfg(h_new, CNT_W) && valid_cfg(v_new, CNT_W);
        offer      = i_cfg_valid && o_cfg_ready;
        v_step     = i_ce && h_last;
        frame_wrap = v_step && v_last;
    end

    video_axis_counter #(.CNT_W(CNT_W)) u_h_axis (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .step      (i_ce),
        .timing    (h_act),
        .pos       (o_hpos),
        .last      (h_last),
        .sync_act  (h_sync_act),
        .blank     (o_hblank),
        .blank_nxt (h_blank_nxt)
    );

    video_axis_counter #(.CNT_W(CNT_W)) u_v_axis (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .step      (v_step),
        .timing    (v_act),
        .pos       (o_vpos),
        .last      (v_last),
        .sync_act  (v_sync_act),
        .blank     (o_vblank),
        .blank_nxt (v_blank_nxt)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_act         <= H_RST;
            v_act         <= V_RST;
            h_shadow      <= H_RST;
            v_shadow      <= V_RST;
            o_cfg_ready   <= 1'b1;
            o_cfg_err     <= 1'b0;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
            o_frame_cnt   <= '0;
            o_visible     <= 1'b1;
        end else begin
            o_cfg_err <= offer && !cfg_ok;
            // Accept needs ready=1 and apply needs ready=0, so an accept on a wrap waits for the next wrap.
            if (offer && cfg_ok) begin
                h_shadow    <= h_new;
                v_shadow    <= v_new;
                o_cfg_ready <= 1'b0;
            end else if (!o_cfg_ready && frame_wrap) begin
                h_act       <= h_shadow;
                v_act       <= v_shadow;
                o_cfg_ready <= 1'b1;
            end
            o_line_start  <= v_step;
            o_frame_start <= frame_wrap;
            if (frame_wrap) begin
                o_frame_cnt <= o_frame_cnt + 1'b1;
            end
            o_visible <= !h_blank_nxt && !v_blank_nxt;
        end
    end

    assign o_hsync = (HSYNC_POL != 0) ? h_sync_act : !h_sync_act;
    assign o_vsync = (VSYNC_POL != 0) ? v_sync_act : !v_sync_act;

endmodule
